// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// error codes and the request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } lsu_state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

  // Stores have no unsigned variants, so only B/H/W are legal for them.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    case (f3[1:0])
      2'b01:   mis = addr_lo[0];
      2'b10:   mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: store byte enables / data replication and
// load byte/half extraction with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    case (addr_lo)
      2'b00:   ld_byte = ld_word[7:0];
      2'b01:   ld_byte = ld_word[15:8];
      2'b10:   ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
  end

  // funct3[2] marks the unsigned load variants.
  always_comb begin
    be       = 4'b1111;
    st_lanes = st_data;
    ld_data  = ld_word;
    case (funct3[1:0])
      2'b00: begin
        be       = 4'b0001 << addr_lo;
        st_lanes = {4{st_data[7:0]}};
        ld_data  = funct3[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      2'b01: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{st_data[15:0]}};
        ld_data  = funct3[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      default: begin
        be       = 4'b1111;
        st_lanes = st_data;
        ld_data  = ld_word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one access from the core, runs it on the req/ack
// data bus, and returns extended load data or an error report.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int MEM_AW      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              done,
  output logic              err_valid,
  output logic [1:0]        err_code
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  lsu_state_t  state_q,    state_d;
  logic        we_q,       we_d;
  logic [2:0]  funct3_q,   funct3_d;
  logic [31:0] addr_q,     addr_d;
  logic [31:0] wdata_q,    wdata_d;
  logic [4:0]  rd_q,       rd_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [4:0]  wb_rd_q,    wb_rd_d;
  logic [31:0] wb_data_q,  wb_data_d;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_ld;

  lsu_lane_align u_lane_align (
    .funct3   (funct3_q),
    .addr_lo  (addr_q[1:0]),
    .st_data  (wdata_q),
    .ld_word  (mem_rdata),
    .be       (lane_be),
    .st_lanes (lane_wdata),
    .ld_data  (lane_ld)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b0;
      addr_q     <= 32'b0;
      wdata_q    <= 32'b0;
      rd_q       <= 5'b0;
      cnt_q      <= '0;
      err_code_q <= ERR_NONE;
      wb_rd_q    <= 5'b0;
      wb_data_q  <= 32'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      err_code_q <= err_code_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Illegal funct3 takes priority over misalignment; an ack in the cycle the
  // timeout would expire still completes the access.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    err_code_d = err_code_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rd_d     = req_rd;
          cnt_d    = '0;
          if (!f3_legal(req_we, req_funct3)) begin
            state_d    = ERR;
            err_code_d = ERR_ILLEGAL;
          end else if (is_misaligned(req_funct3, req_addr[1:0])) begin
            state_d    = ERR;
            err_code_d = ERR_MISALIGN;
          end else begin
            state_d = BUS;
          end
        end
      end
      BUS: begin
        if (mem_ack) begin
          state_d = DONE;
          if (!we_q && (rd_q != 5'd0)) begin
            wb_rd_d   = rd_q;
            wb_data_d = lane_ld;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            state_d    = ERR;
            err_code_d = ERR_TIMEOUT;
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign mem_req   = (state_q == BUS);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = mem_req ? {addr_q[MEM_AW-1:2], 2'b00} : '0;
  assign mem_be    = mem_req ? lane_be : 4'b0;
  assign mem_wdata = mem_req ? lane_wdata : 32'b0;
  assign wb_valid  = (state_q == DONE) && !we_q && (rd_q != 5'd0);
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign done      = (state_q == DONE) || (state_q == ERR);
  assign err_valid = (state_q == ERR);
  assign err_code  = (state_q == ERR) ? err_code_q : ERR_NONE;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push expected bus
// and completion records; monitors pop and compare as the DUT presents them.
module tb_load_store_unit;

   typedef struct {
      logic        err;
      logic [1:0]  code;
      logic        wbv;
      logic [4:0]  rd;
      logic [31:0] data;
      int          lat;
   } doneExp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } memExp_t;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        done;
   logic        err_valid;
   logic [1:0]  err_code;

   doneExp_t doneQ[$];
   memExp_t  memQ[$];
   int       testsRun;
   int       testsFailed;
   int       cycleCount;
   int       acceptCycle;
   int       doneCount;
   logic     prevMemReq;

   load_store_unit #(.TIMEOUT_CYC(64), .MEM_AW(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_rd     (req_rd),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_be     (mem_be),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .done       (done),
      .err_valid  (err_valid),
      .err_code   (err_code)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: every check in the bench funnels through here.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // Cycle counter plus the counter value at the accepting edge, for latency.
   always @(posedge clk) begin
      cycleCount <= cycleCount + 1;
      if (req_valid && req_ready && !reset) acceptCycle <= cycleCount;
   end

   // Bus monitor: compare address/lanes on the first cycle of each request.
   always @(negedge clk) begin
      if (reset) begin
         prevMemReq <= 1'b0;
      end else begin
         prevMemReq <= mem_req;
         if (mem_req && !prevMemReq) begin
            if (memQ.size() == 0) begin
               checkOutput("unexpected_mem_req", {31'b0, mem_req}, 32'd0);
            end else begin
               memExp_t m;
               m = memQ.pop_front();
               checkOutput("mem_we", {31'b0, mem_we}, {31'b0, m.we});
               checkOutput("mem_addr", mem_addr, m.addr);
               checkOutput("mem_be", {28'b0, mem_be}, {28'b0, m.be});
               if (m.we) checkOutput("mem_wdata", mem_wdata, m.wdata);
            end
         end
      end
   end

   // Completion monitor: compare status, writeback and latency on each done.
   always @(negedge clk) begin
      if (!reset && done) begin
         doneCount <= doneCount + 1;
         if (doneQ.size() == 0) begin
            checkOutput("unexpected_done", {31'b0, done}, 32'd0);
         end else begin
            doneExp_t e;
            e = doneQ.pop_front();
            checkOutput("err_valid", {31'b0, err_valid}, {31'b0, e.err});
            checkOutput("err_code", {30'b0, err_code}, {30'b0, e.code});
            checkOutput("wb_valid", {31'b0, wb_valid}, {31'b0, e.wbv});
            if (e.wbv) begin
               checkOutput("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
               checkOutput("wb_data", wb_data, e.data);
            end
            checkOutput("latency", 32'(cycleCount - acceptCycle), 32'(e.lat));
         end
      end
   end

   // Wait for ready, present one access, then play the bus side.
   // ackDelay < 0 means the bus never answers.
   task automatic applyStimulus(
      input logic we, input logic [2:0] f3, input logic [31:0] addr,
      input logic [31:0] wdata, input logic [4:0] rd,
      input int ackDelay, input logic [31:0] rdata,
      input logic busExp, input logic [3:0] beExp, input logic [31:0] wdataExp,
      input logic errExp, input logic [1:0] codeExp,
      input logic wbvExp, input logic [31:0] dataExp, input int latExp);
      int n;
      doneExp_t d;
      memExp_t  m;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) checkOutput("ready_timeout", {31'b0, req_ready}, 32'd1);
      if (busExp) begin
         m.we = we; m.addr = {addr[31:2], 2'b00}; m.be = beExp; m.wdata = wdataExp;
         memQ.push_back(m);
      end
      d.err = errExp; d.code = codeExp; d.wbv = wbvExp; d.rd = rd; d.data = dataExp; d.lat = latExp;
      doneQ.push_back(d);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      req_rd     = rd;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      if (ackDelay >= 0) begin
         repeat (ackDelay) @(negedge clk);
         mem_ack   = 1'b1;
         mem_rdata = rdata;
         @(negedge clk);
         mem_ack = 1'b0;
      end
   endtask

   initial begin
      int n;
      int savedDone;
      testsRun    = 0;
      testsFailed = 0;
      cycleCount  = 0;
      acceptCycle = 0;
      doneCount   = 0;
      reset       = 1'b1;
      req_valid   = 1'b0;
      req_we      = 1'b0;
      req_funct3  = 3'b0;
      req_addr    = 32'b0;
      req_wdata   = 32'b0;
      req_rd      = 5'b0;
      mem_ack     = 1'b0;
      mem_rdata   = 32'b0;
      repeat (3) @(negedge clk);
      checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
      checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
      checkOutput("rst_done", {31'b0, done}, 32'd0);
      checkOutput("rst_err_valid", {31'b0, err_valid}, 32'd0);
      checkOutput("rst_wb_data", wb_data, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Stores: SB high byte, SH upper half, SW.
      applyStimulus(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd0, 2, 32'h0,
                    1'b1, 4'b1000, 32'hA5A5_A5A5, 1'b0, 2'b00, 1'b0, 32'h0, 4);
      applyStimulus(1'b1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 5'd0, 0, 32'h0,
                    1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b0, 2'b00, 1'b0, 32'h0, 2);
      applyStimulus(1'b1, 3'b010, 32'h0000_1004, 32'hCAFE_F00D, 5'd0, 1, 32'h0,
                    1'b1, 4'b1111, 32'hCAFE_F00D, 1'b0, 2'b00, 1'b0, 32'h0, 3);

      // Loads: sign/zero extension of bytes and halves, full word.
      applyStimulus(1'b0, 3'b000, 32'h0000_2001, 32'h0, 5'd5, 0, 32'h0000_8000,
                    1'b1, 4'b0010, 32'h0, 1'b0, 2'b00, 1'b1, 32'hFFFF_FF80, 2);
      applyStimulus(1'b0, 3'b100, 32'h0000_2001, 32'h0, 5'd5, 0, 32'h0000_8000,
                    1'b1, 4'b0010, 32'h0, 1'b0, 2'b00, 1'b1, 32'h0000_0080, 2);
      applyStimulus(1'b0, 3'b001, 32'h0000_2002, 32'h0, 5'd7, 0, 32'h7FFF_1234,
                    1'b1, 4'b1100, 32'h0, 1'b0, 2'b00, 1'b1, 32'h0000_7FFF, 2);
      applyStimulus(1'b0, 3'b001, 32'h0000_2000, 32'h0, 5'd8, 0, 32'h1234_8001,
                    1'b1, 4'b0011, 32'h0, 1'b0, 2'b00, 1'b1, 32'hFFFF_8001, 2);
      applyStimulus(1'b0, 3'b101, 32'h0000_2000, 32'h0, 5'd9, 0, 32'h1234_8001,
                    1'b1, 4'b0011, 32'h0, 1'b0, 2'b00, 1'b1, 32'h0000_8001, 2);
      applyStimulus(1'b0, 3'b010, 32'h0000_2004, 32'h0, 5'd10, 1, 32'h89AB_CDEF,
                    1'b1, 4'b1111, 32'h0, 1'b0, 2'b00, 1'b1, 32'h89AB_CDEF, 3);

      // Errors: misaligned word, illegal load funct3, illegal store funct3,
      // and illegal-plus-misaligned reports illegal.
      applyStimulus(1'b0, 3'b010, 32'h0000_2002, 32'h0, 5'd4, -1, 32'h0,
                    1'b0, 4'b0, 32'h0, 1'b1, 2'b01, 1'b0, 32'h0, 1);
      applyStimulus(1'b0, 3'b011, 32'h0000_2000, 32'h0, 5'd4, -1, 32'h0,
                    1'b0, 4'b0, 32'h0, 1'b1, 2'b10, 1'b0, 32'h0, 1);
      applyStimulus(1'b1, 3'b101, 32'h0000_2000, 32'h0, 5'd0, -1, 32'h0,
                    1'b0, 4'b0, 32'h0, 1'b1, 2'b10, 1'b0, 32'h0, 1);
      applyStimulus(1'b1, 3'b110, 32'h0000_2003, 32'h0, 5'd0, -1, 32'h0,
                    1'b0, 4'b0, 32'h0, 1'b1, 2'b10, 1'b0, 32'h0, 1);
      applyStimulus(1'b0, 3'b001, 32'h0000_2003, 32'h0, 5'd4, -1, 32'h0,
                    1'b0, 4'b0, 32'h0, 1'b1, 2'b01, 1'b0, 32'h0, 1);

      // LW to x0: completes but never strobes the regfile.
      applyStimulus(1'b0, 3'b010, 32'h0000_2008, 32'h0, 5'd0, 0, 32'h1111_2222,
                    1'b1, 4'b1111, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0, 2);

      // Bus timeout after 64 unacknowledged cycles.
      applyStimulus(1'b0, 3'b010, 32'h0000_3000, 32'h0, 5'd11, -1, 32'h0,
                    1'b1, 4'b1111, 32'h0, 1'b1, 2'b11, 1'b0, 32'h0, 65);
      n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("timeout_done_seen", {31'b0, done}, 32'd1);
      checkOutput("timeout_mem_req_low", {31'b0, mem_req}, 32'd0);
      @(negedge clk);
      checkOutput("timeout_ready_next", {31'b0, req_ready}, 32'd1);

      // Ack on the 64th bus cycle still succeeds.
      applyStimulus(1'b0, 3'b010, 32'h0000_3004, 32'h0, 5'd12, 63, 32'hDEAD_BEEF,
                    1'b1, 4'b1111, 32'h0, 1'b0, 2'b00, 1'b1, 32'hDEAD_BEEF, 65);

      // Reset in the middle of a bus transaction, then a stale ack.
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      begin
         memExp_t m;
         m.we = 1'b0; m.addr = 32'h0000_4000; m.be = 4'b1111; m.wdata = 32'h0;
         memQ.push_back(m);
      end
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h0000_4000;
      req_rd     = 5'd3;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      checkOutput("pre_reset_mem_req", {31'b0, mem_req}, 32'd1);
      savedDone = doneCount;
      reset = 1'b1;
      #1;
      checkOutput("reset_mem_req", {31'b0, mem_req}, 32'd0);
      checkOutput("reset_req_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);
      reset = 1'b0;
      mem_ack   = 1'b1;
      mem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      mem_ack = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("reset_no_done", 32'(doneCount), 32'(savedDone));
      checkOutput("reset_wb_rd_hold", {27'b0, wb_rd}, 32'd0);

      n = 0;
      while ((doneQ.size() != 0 || memQ.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("done_queue_drained", 32'(doneQ.size()), 32'd0);
      checkOutput("mem_queue_drained", 32'(memQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // Absolute backstop so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout actual=running expected=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule
